// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller for the 5-stage MIPS core.
// Produces forwarding selects for the decode-stage branch comparator and the
// execute-stage ALU operand muxes, load-use / branch / MULT-DIV stalls, and
// sequences the multi-cycle MULT/DIV unit with a small busy FSM.
// Optional feature: define HAZARD_PERF_CNT_EN to add saturating stall and
// MULT/DIV operation counters (stall_cnt, md_ops_cnt).
module hazard_unit #(
  parameter int unsigned MD_LATENCY = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       MultDivE,
  input  logic       MultDivUseD,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       md_busy,
  output logic       md_done
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] md_ops_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(MD_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             md_start_s;
  logic             lwstall_s, branchstall_s, mdstall_s, hazard_s;

  // Register $0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  // Forward select for one ALU operand: M stage wins over W stage.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    logic [1:0] sel;
    if (RegWriteM && reg_match(src, WriteRegM)) begin
      sel = 2'b10;
    end else if (RegWriteW && reg_match(src, WriteRegW)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Hazard detection terms.
  always_comb begin
    lwstall_s     = MemtoRegE && (reg_match(RtE, RsD) || reg_match(RtE, RtD));
    branchstall_s = BranchD &&
                    ((RegWriteE && (reg_match(WriteRegE, RsD) || reg_match(WriteRegE, RtD))) ||
                     (MemtoRegM && (reg_match(WriteRegM, RsD) || reg_match(WriteRegM, RtD))));
    mdstall_s     = MultDivUseD && (md_busy || MultDivE);
    hazard_s      = lwstall_s || branchstall_s || mdstall_s;
  end

  // Pipeline control outputs; held at a safe bubble-inserting value in reset.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushE    = 1'b1;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst_n) begin
      StallF    = hazard_s;
      StallD    = hazard_s;
      FlushE    = hazard_s;
      ForwardAD = RegWriteM && reg_match(RsD, WriteRegM);
      ForwardBD = RegWriteM && reg_match(RtD, WriteRegM);
      ForwardAE = fwd_sel(RsE);
      ForwardBE = fwd_sel(RtE);
    end else begin
      StallF = 1'b0;
    end
  end

  // MULT/DIV busy FSM next-state and status outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    md_busy    = 1'b0;
    md_done    = 1'b0;
    md_start_s = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (MultDivE) begin
          state_d    = MD_BUSY;
          cnt_d      = CNT_LOAD;
          md_start_s = 1'b1;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      MD_BUSY: begin
        // A new MultDivE here is ignored: the counter is never reloaded.
        md_busy = 1'b1;
        if (cnt_q == CNT_ZERO) begin
          md_done = 1'b1;
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // MULT/DIV FSM state and countdown registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, md_ops_cnt_q;

  // Saturating performance counters for decode stalls and MULT/DIV starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= 32'd0;
      md_ops_cnt_q <= 32'd0;
    end else begin
      if (StallD && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (md_start_s && (md_ops_cnt_q != 32'hFFFF_FFFF)) begin
        md_ops_cnt_q <= md_ops_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign md_ops_cnt = md_ops_cnt_q;
`endif

endmodule
